// File: rtl/cache_mem_ctrl.sv
// cache_mem_ctrl: icache/dcache responder in front of a single-port RAM, dcache priority,
//   two-word burst lock, starvation guard for icache, latency watchdog into a sticky ERR.
// Latency: grant registered one cycle after a request is seen in IDLE, word done on ram_ready.
// Backpressure: iwait/dwait stay high until the RAM completes; no RAM-side queuing.
// Optional feature macro: MEMCTRL_STATS_EN (d_xfers/i_xfers word counters; tied 0 otherwise).
module cache_mem_ctrl #(
  parameter int LAT_MAX    = 16,
  parameter int STARVE_MAX = 4
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ram_REN,
  output logic        ram_WEN,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_store,
  input  logic [31:0] ram_load,
  input  logic        ram_ready,
  output logic        err,
  output logic [15:0] d_xfers,
  output logic [15:0] i_xfers
);

  typedef enum logic [1:0] {IDLE, DSRV, ISRV, ERR} state_t;

  localparam logic [7:0]  STARVE_LIM = 8'(STARVE_MAX);
  localparam logic [15:0] WD_LIM     = 16'(LAT_MAX - 1);

  state_t      state;
  logic        lock;
  logic [7:0]  starve_ct;
  logic [15:0] wd_ct;

  logic d_req;
  logic d_done;
  logic i_done;
  logic force_i;
  logic lock_next;
  logic wd_expire;

  assign d_req  = dREN | dWEN;
  // a completion only counts while the requester is still asking; otherwise the result is dropped
  assign d_done = (state == DSRV) && ram_ready && d_req;
  assign i_done = (state == ISRV) && ram_ready && iREN;

  assign force_i   = (starve_ct == STARVE_LIM) && iREN && !lock;
  // first word of an even/odd pair opens the lock; the following D completion closes it
  assign lock_next = !lock && !daddr[2];
  assign wd_expire = (LAT_MAX != 0) && (wd_ct == WD_LIM);

  // addresses and write data are forwarded from the granted requester, not captured
  assign ram_addr  = (state == DSRV) ? daddr :
                     (state == ISRV) ? iaddr : 32'h0;
  assign ram_store = ((state == DSRV) && ram_WEN) ? dstore : 32'h0;

  assign dwait = !d_done;
  assign iwait = !i_done;
  assign dload = ram_load;
  assign iload = ram_load;

  // arbitration FSM with registered RAM strobes, lock, starvation and watchdog state
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= IDLE;
      ram_REN   <= 1'b0;
      ram_WEN   <= 1'b0;
      err       <= 1'b0;
      lock      <= 1'b0;
      starve_ct <= 8'd0;
      wd_ct     <= 16'd0;
    end else begin
      case (state)
        IDLE: begin
          wd_ct <= 16'd0;
          if (force_i) begin
            state   <= ISRV;
            ram_REN <= 1'b1;
          end else if (d_req) begin
            state   <= DSRV;
            ram_WEN <= dWEN;
            ram_REN <= !dWEN;
          end else if (iREN) begin
            state   <= ISRV;
            ram_REN <= 1'b1;
          end
        end
        DSRV, ISRV: begin
          if (ram_ready) begin
            wd_ct <= 16'd0;
            if (d_done && lock_next) begin
              // locked second word is granted straight away, no IDLE gap
              state   <= DSRV;
              ram_WEN <= dWEN;
              ram_REN <= !dWEN;
            end else begin
              state   <= IDLE;
              ram_REN <= 1'b0;
              ram_WEN <= 1'b0;
            end
          end else if (wd_expire) begin
            state   <= ERR;
            err     <= 1'b1;
            ram_REN <= 1'b0;
            ram_WEN <= 1'b0;
          end else begin
            wd_ct <= wd_ct + 16'd1;
          end
        end
        default: begin
          // ERR is terminal until reset
          state   <= ERR;
          ram_REN <= 1'b0;
          ram_WEN <= 1'b0;
        end
      endcase

      if (d_done)
        lock <= lock_next;
      else if (!d_req)
        lock <= 1'b0;

      if (i_done || !iREN)
        starve_ct <= 8'd0;
      else if (d_done && (starve_ct < STARVE_LIM))
        starve_ct <= starve_ct + 8'd1;
    end
  end

`ifdef MEMCTRL_STATS_EN
  logic [15:0] d_ct;
  logic [15:0] i_ct;

  // completed-word counters; no completions occur in ERR so they freeze there
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      d_ct <= 16'd0;
      i_ct <= 16'd0;
    end else begin
      if (d_done) d_ct <= d_ct + 16'd1;
      if (i_done) i_ct <= i_ct + 16'd1;
    end
  end

  assign d_xfers = d_ct;
  assign i_xfers = i_ct;
`else
  assign d_xfers = 16'h0;
  assign i_xfers = 16'h0;
`endif

endmodule

// File: tb/tb_cache_mem_ctrl.sv
// Bench for cache_mem_ctrl: directed cache requests, behavioural RAM with programmable latency,
// and a scoreboard queue of expected word completions popped by an independent monitor.
module tb_cache_mem_ctrl;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        iREN, dREN, dWEN, ram_ready;
  logic [31:0] iaddr, daddr, dstore, ram_load;
  logic        iwait, dwait, ram_REN, ram_WEN, err;
  logic [31:0] iload, dload, ram_addr, ram_store;
  logic [15:0] d_xfers, i_xfers;

  cache_mem_ctrl #(.LAT_MAX(16), .STARVE_MAX(4)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ram_REN(ram_REN), .ram_WEN(ram_WEN), .ram_addr(ram_addr), .ram_store(ram_store),
    .ram_load(ram_load), .ram_ready(ram_ready),
    .err(err), .d_xfers(d_xfers), .i_xfers(i_xfers)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        is_i;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  int          last_d_cyc = 0;
  int          prev_d_cyc = 0;
  int          ram_lat = 1;
  logic [31:0] mem [0:255];

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h want 0x%08h (cycle %0d)", nm, act, want, cyc);
    end
  endfunction

  function automatic void chk1(input string nm, input logic act, input logic want);
    chk(nm, {31'h0, act}, {31'h0, want});
  endfunction

  function automatic void push(input logic is_i, input logic wr, input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    e.is_i = is_i; e.wr = wr; e.addr = a; e.data = d;
    exp_q.push_back(e);
  endfunction

  initial forever begin
    @(posedge CLK);
    cyc++;
  end

  // behavioural RAM: ready pulse after ram_lat cycles of strobe, acts 2 time units after the edge
  initial begin
    int cnt;
    cnt = 0;
    ram_ready = 1'b0;
    ram_load = 32'h0;
    for (int i = 0; i < 256; i++) mem[i] = 32'hC000_0000 | i;
    mem[16] = 32'hDEAD_BEEF;
    forever begin
      @(posedge CLK);
      #2;
      ram_ready = 1'b0;
      if (nRST && (ram_REN || ram_WEN)) begin
        cnt++;
        if (cnt >= ram_lat) begin
          ram_ready = 1'b1;
          cnt = 0;
          if (ram_WEN) mem[ram_addr[9:2]] = ram_store;
          else         ram_load = mem[ram_addr[9:2]];
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // monitor: every completed word must match the head of the expected queue
  initial forever begin
    @(negedge CLK);
    if (nRST && (!dwait || !iwait)) begin
      chk1("single_done", !dwait && !iwait, 1'b0);
      if (!dwait) begin
        prev_d_cyc = last_d_cyc;
        last_d_cyc = cyc;
      end
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_done: dwait=%0b iwait=%0b addr 0x%08h, none expected", dwait, iwait, ram_addr);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk1("grant_side", !iwait, e.is_i);
        chk("ram_addr", ram_addr, e.addr);
        if (e.is_i) begin
          chk("iload", iload, e.data);
          chk1("i_ram_REN", ram_REN, 1'b1);
        end else if (e.wr) begin
          chk("ram_store", ram_store, e.data);
          chk1("w_ram_WEN", ram_WEN, 1'b1);
          chk1("w_ram_REN", ram_REN, 1'b0);
        end else begin
          chk("dload", dload, e.data);
          chk1("r_ram_REN", ram_REN, 1'b1);
          chk1("r_ram_WEN", ram_WEN, 1'b0);
        end
      end
    end
  end

  task automatic d_go(input logic wr, input logic rd, input logic [31:0] a, input logic [31:0] st);
    bit ok;
    dWEN = wr; dREN = rd; daddr = a; dstore = st;
    ok = 0;
    for (int n = 0; n < 100; n++) begin
      @(negedge CLK);
      if (!dwait) begin ok = 1; break; end
    end
    if (!ok) begin
      vectors++; miscompares++;
      $display("FAIL d_timeout: dwait stuck at 1 for addr 0x%08h, want a low pulse", a);
    end
    @(posedge CLK); #1;
  endtask

  task automatic i_go(input logic [31:0] a);
    bit ok;
    iREN = 1'b1; iaddr = a;
    ok = 0;
    for (int n = 0; n < 100; n++) begin
      @(negedge CLK);
      if (!iwait) begin ok = 1; break; end
    end
    if (!ok) begin
      vectors++; miscompares++;
      $display("FAIL i_timeout: iwait stuck at 1 for addr 0x%08h, want a low pulse", a);
    end
    @(posedge CLK); #1;
    iREN = 1'b0;
  endtask

  task automatic gap();
    dREN = 1'b0; dWEN = 1'b0;
    repeat (10) @(posedge CLK);
    #1;
  endtask

  task automatic wait_strobe();
    bit ok;
    ok = 0;
    for (int n = 0; n < 10; n++) begin
      @(negedge CLK);
      if (ram_REN) begin ok = 1; break; end
    end
    if (!ok) begin
      vectors++; miscompares++;
      $display("FAIL strobe_timeout: ram_REN stayed 0, want 1");
    end
  endtask

  task automatic reset_checks(input string tag);
    chk1({tag, "_iwait"}, iwait, 1'b1);
    chk1({tag, "_dwait"}, dwait, 1'b1);
    chk1({tag, "_ram_REN"}, ram_REN, 1'b0);
    chk1({tag, "_ram_WEN"}, ram_WEN, 1'b0);
    chk({tag, "_ram_addr"}, ram_addr, 32'h0);
    chk({tag, "_ram_store"}, ram_store, 32'h0);
    chk1({tag, "_err"}, err, 1'b0);
    chk({tag, "_xfers"}, {d_xfers, i_xfers}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at %0t, want completion", $time);
    $fatal(1, "global timeout");
  end

  initial begin
    nRST = 1'b0;
    iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
    iaddr = 32'h0; daddr = 32'h0; dstore = 32'h0;
    repeat (3) @(negedge CLK);
    reset_checks("rst");
    @(posedge CLK); #1;
    nRST = 1'b1;
    repeat (2) @(posedge CLK); #1;

    // T1: single read, RAM answers on the third strobe cycle
    ram_lat = 3;
    push(1'b0, 1'b0, 32'h40, 32'hDEAD_BEEF);
    d_go(1'b0, 1'b1, 32'h40, 32'h0);
    gap();

    // T2: read+write together performs the write only; then read it back
    ram_lat = 2;
    push(1'b0, 1'b1, 32'h80, 32'h0000_1234);
    d_go(1'b1, 1'b1, 32'h80, 32'h0000_1234);
    gap();
    ram_lat = 1;
    push(1'b0, 1'b0, 32'h80, 32'h0000_1234);
    d_go(1'b0, 1'b1, 32'h80, 32'h0);
    gap();

    // T3: simultaneous I and D, D goes first
    ram_lat = 2;
    push(1'b0, 1'b0, 32'h44, 32'hC000_0011);
    push(1'b1, 1'b0, 32'h10, 32'hC000_0004);
    fork
      begin d_go(1'b0, 1'b1, 32'h44, 32'h0); dREN = 1'b0; end
      i_go(32'h10);
    join
    gap();

    // T4: locked two-word burst, I waits until after the second word
    ram_lat = 2;
    push(1'b0, 1'b0, 32'h100, 32'hC000_0040);
    push(1'b0, 1'b0, 32'h104, 32'hC000_0041);
    push(1'b1, 1'b0, 32'h18, 32'hC000_0006);
    fork
      begin
        d_go(1'b0, 1'b1, 32'h100, 32'h0);
        d_go(1'b0, 1'b1, 32'h104, 32'h0);
        dREN = 1'b0;
      end
      i_go(32'h18);
    join
    chk("burst_gap_cycles", 32'(last_d_cyc - prev_d_cyc), 32'd2);
    gap();

    // T5: four unlocked D words with I pending, fifth grant goes to I
    ram_lat = 1;
    push(1'b0, 1'b0, 32'h204, 32'hC000_0081);
    push(1'b0, 1'b0, 32'h20C, 32'hC000_0083);
    push(1'b0, 1'b0, 32'h214, 32'hC000_0085);
    push(1'b0, 1'b0, 32'h21C, 32'hC000_0087);
    push(1'b1, 1'b0, 32'h14, 32'hC000_0005);
    push(1'b0, 1'b0, 32'h224, 32'hC000_0089);
    fork
      begin
        d_go(1'b0, 1'b1, 32'h204, 32'h0);
        d_go(1'b0, 1'b1, 32'h20C, 32'h0);
        d_go(1'b0, 1'b1, 32'h214, 32'h0);
        d_go(1'b0, 1'b1, 32'h21C, 32'h0);
        d_go(1'b0, 1'b1, 32'h224, 32'h0);
        dREN = 1'b0;
      end
      i_go(32'h14);
    join
    gap();
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
`ifdef MEMCTRL_STATS_EN
    chk("d_xfers", {16'h0, d_xfers}, 32'd11);
    chk("i_xfers", {16'h0, i_xfers}, 32'd3);
`else
    chk("stats_tied", {d_xfers, i_xfers}, 32'h0);
`endif

    // T6a: RAM never answers; ERR after 16 stalled cycles
    ram_lat = 1000;
    dREN = 1'b1; daddr = 32'h304;
    wait_strobe();
    repeat (15) @(posedge CLK);
    #1;
    chk1("err_before_limit", err, 1'b0);
    chk1("strobe_before_limit", ram_REN, 1'b1);
    @(posedge CLK); #1;
    chk1("err_at_limit", err, 1'b1);
    chk1("err_ram_REN", ram_REN, 1'b0);
    chk1("err_dwait", dwait, 1'b1);
    dREN = 1'b0;
    repeat (3) @(posedge CLK); #1;
    chk1("err_sticky", err, 1'b1);
    nRST = 1'b0;
    #1;
    reset_checks("err_rst");
    @(posedge CLK); #1;
    nRST = 1'b1;
    repeat (2) @(posedge CLK); #1;

    // T6b: reset in the middle of a D service drops strobes immediately
    dREN = 1'b1; daddr = 32'h30C;
    wait_strobe();
    @(posedge CLK); #3;
    chk1("mid_pre_ram_REN", ram_REN, 1'b1);
    chk("mid_pre_ram_addr", ram_addr, 32'h30C);
    nRST = 1'b0;
    #1;
    chk1("mid_rst_ram_REN", ram_REN, 1'b0);
    chk("mid_rst_ram_addr", ram_addr, 32'h0);
    chk1("mid_rst_dwait", dwait, 1'b1);
    dREN = 1'b0;
    @(posedge CLK); #1;
    nRST = 1'b1;
    repeat (3) @(posedge CLK); #1;
    chk("final_queue_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
